// File: rtl/axi_decerr_slave.sv
// AXI default slave: answers every write and read burst with RESP (DECERR).
// Define AXI_DECERR_SLAVE_RDATA_PATTERN_EN to return DEADBEEF on R data.
module axi_decerr_slave #(
  parameter int          ID_WIDTH   = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [1:0]  RESP       = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic                r_live;
  logic [1:0]          r_wstate;
  logic [0:0]          r_rstate;
  logic [ID_WIDTH-1:0] r_bid;
  logic [ID_WIDTH-1:0] r_rid;
  logic [7:0]          r_rcnt;

  logic w_aw_hs;
  logic w_ar_hs;
  logic w_rdata_phase;

  // r_live keeps the ready outputs low during the reset cycle itself
  assign s_axi_awready = r_live && (r_wstate == W_IDLE);
  assign s_axi_wready  = (r_wstate == W_DATA);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = s_axi_bvalid ? RESP : 2'b00;

  assign w_rdata_phase = (r_rstate == R_DATA);
  assign s_axi_arready = r_live && (r_rstate == R_IDLE);
  assign s_axi_rvalid  = w_rdata_phase;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = w_rdata_phase ? RESP : 2'b00;
  assign s_axi_rlast   = w_rdata_phase && (r_rcnt == 8'd0);

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

`ifdef AXI_DECERR_SLAVE_RDATA_PATTERN_EN
  function automatic logic [DATA_WIDTH-1:0] f_pat();
    logic [31:0]           w;
    logic [DATA_WIDTH-1:0] p;
    w = 32'hDEADBEEF;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      p = {w[0], p[DATA_WIDTH-1:1]};
      w = {w[0], w[31:1]};
    end
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] PAT = f_pat();

  assign s_axi_rdata = w_rdata_phase ? PAT : '0;
`else
  assign s_axi_rdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_wstate <= W_IDLE;
      r_bid    <= '0;
    end else begin
      r_live <= 1'b1;
      unique case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_bid    <= s_axi_awid;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid && s_axi_wlast) r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_rcnt   <= 8'd0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rid    <= s_axi_arid;
            r_rcnt   <= s_axi_arlen;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          // counter stops at zero, so arlen=255 cannot wrap
          if (s_axi_rready) begin
            if (r_rcnt == 8'd0) r_rstate <= R_IDLE;
            else                r_rcnt   <= r_rcnt - 8'd1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Scoreboard bench for axi_decerr_slave (64-bit data, 8-bit IDs).
// Expected B/R beats are queued at request time and popped at handshakes.
module tb_axi_decerr_slave;

  localparam int IW = 8;
  localparam int DW = 64;

`ifdef AXI_DECERR_SLAVE_RDATA_PATTERN_EN
  localparam logic [63:0] EXP_DATA = 64'hDEADBEEFDEADBEEF;
`else
  localparam logic [63:0] EXP_DATA = 64'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] awid = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [IW-1:0] arid = '0;
  logic [7:0]    arlen = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;

  int total = 0;
  int bad = 0;
  int rmode = 0;

  logic [IW-1:0] q_rid[$];
  logic          q_rlast[$];
  logic [IW-1:0] q_bid[$];

  always #5 clk = ~clk;

  axi_decerr_slave #(
    .ID_WIDTH(IW),
    .DATA_WIDTH(DW),
    .RESP(2'b11)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi_awid(awid),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid),
    .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid),
    .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid),
    .s_axi_rdata(rdata),
    .s_axi_rresp(rresp),
    .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid),
    .s_axi_rready(rready)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // random rready when rmode==1, otherwise the main thread owns it
  always @(posedge clk) begin
    #1;
    if (rmode == 1) rready = 1'($urandom_range(0, 1));
  end

  logic          r_stall = 1'b0;
  logic [IW-1:0] r_sv_id;
  logic          r_sv_last;
  logic [DW-1:0] r_sv_data;
  logic          b_stall = 1'b0;
  logic [IW-1:0] b_sv_id;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (rvalid) begin
        if (r_stall) begin
          check("r_stable_id", 64'(rid), 64'(r_sv_id));
          check("r_stable_last", 64'(rlast), 64'(r_sv_last));
          check("r_stable_data", rdata, r_sv_data);
        end
        if (rready) begin
          r_stall = 1'b0;
          if (q_rid.size() == 0) begin
            check("r_extra_beat", 64'd1, 64'd0);
          end else begin
            check("rid", 64'(rid), 64'(q_rid.pop_front()));
            check("rlast", 64'(rlast), 64'(q_rlast.pop_front()));
            check("rresp", 64'(rresp), 64'd3);
            check("rdata", rdata, EXP_DATA);
          end
        end else begin
          r_stall = 1'b1;
          r_sv_id = rid;
          r_sv_last = rlast;
          r_sv_data = rdata;
        end
      end
      if (bvalid) begin
        if (b_stall) check("b_stable_id", 64'(bid), 64'(b_sv_id));
        if (bready) begin
          b_stall = 1'b0;
          if (q_bid.size() == 0) begin
            check("b_extra", 64'd1, 64'd0);
          end else begin
            check("bid", 64'(bid), 64'(q_bid.pop_front()));
            check("bresp", 64'(bresp), 64'd3);
          end
        end else begin
          b_stall = 1'b1;
          b_sv_id = bid;
        end
      end
    end
  end

  task automatic do_aw(input logic [IW-1:0] id);
    int n;
    awvalid = 1'b1;
    awid = id;
    n = 0;
    while (!awready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("aw_timeout", 64'd1, 64'd0);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic do_w(input int beats, input logic [IW-1:0] id);
    int n;
    for (int i = 0; i < beats; i++) begin
      wvalid = 1'b1;
      wlast = (i == beats - 1);
      n = 0;
      while (!wready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) check("w_timeout", 64'd1, 64'd0);
      if (wlast) q_bid.push_back(id);
      tick();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [7:0] len);
    int n;
    arvalid = 1'b1;
    arid = id;
    arlen = len;
    n = 0;
    while (!arready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ar_timeout", 64'd1, 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      q_rid.push_back(id);
      q_rlast.push_back(i == int'(len));
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_r(input int left, input int budget);
    int n;
    n = 0;
    while (q_rid.size() > left && n < budget) begin
      tick();
      n++;
    end
    if (n == budget) check("r_timeout", 64'(q_rid.size()), 64'(left));
  endtask

  task automatic wait_b(input int budget);
    int n;
    n = 0;
    while (q_bid.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (n == budget) check("b_timeout", 64'(q_bid.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // write burst, 4 beats
    bready = 1'b0;
    do_aw(8'h5A);
    do_w(4, 8'h5A);
    check("bvalid_after_wlast", 64'(bvalid), 64'd1);
    check("awready_in_resp", 64'(awready), 64'd0);
    bready = 1'b1;
    wait_b(20);
    bready = 1'b0;
    check("awready_back", 64'(awready), 64'd1);
    check("bvalid_drop", 64'(bvalid), 64'd0);

    // single-beat read
    rmode = 0;
    rready = 1'b1;
    do_ar(8'h11, 8'd0);
    check("rvalid_next", 64'(rvalid), 64'd1);
    wait_r(0, 20);
    check("arready_back", 64'(arready), 64'd1);
    check("rvalid_drop", 64'(rvalid), 64'd0);

    // 256-beat read with random backpressure
    rmode = 1;
    do_ar(8'h42, 8'd255);
    wait_r(0, 3000);
    rmode = 0;
    rready = 1'b0;
    tick();
    check("long_done_rvalid", 64'(rvalid), 64'd0);
    check("long_done_arready", 64'(arready), 64'd1);

    // W before AW stalls; B held under bready=0
    wvalid = 1'b1;
    wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("wready_pre_aw", 64'(wready), 64'd0);
      tick();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    do_aw(8'h77);
    do_w(1, 8'h77);
    awvalid = 1'b1;
    awid = 8'h99;
    for (int i = 0; i < 10; i++) begin
      check("bvalid_hold", 64'(bvalid), 64'd1);
      check("bid_hold", 64'(bid), 64'h77);
      check("no_second_aw", 64'(awready), 64'd0);
      tick();
    end
    awvalid = 1'b0;
    bready = 1'b1;
    wait_b(20);
    bready = 1'b0;

    // reset during beat 3 of an 8-beat read
    rready = 1'b1;
    do_ar(8'h22, 8'd7);
    wait_r(6, 50);
    rready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_arready", 64'(arready), 64'd0);
    check("midrst_rid", 64'(rid), 64'd0);
    q_rid.delete();
    q_rlast.delete();
    rst_n = 1'b1;
    tick();
    check("midrst_arready_back", 64'(arready), 64'd1);
    check("midrst_no_rvalid", 64'(rvalid), 64'd0);
    rready = 1'b1;
    do_ar(8'h33, 8'd1);
    wait_r(0, 50);
    tick();
    check("post_rst_read_idle", 64'(rvalid), 64'd0);

    // same-cycle AW and AR
    rready = 1'b0;
    check("both_awready", 64'(awready), 64'd1);
    check("both_arready", 64'(arready), 64'd1);
    awvalid = 1'b1;
    awid = 8'hA1;
    arvalid = 1'b1;
    arid = 8'hB2;
    arlen = 8'd0;
    q_rid.push_back(8'hB2);
    q_rlast.push_back(1'b1);
    tick();
    awvalid = 1'b0;
    arvalid = 1'b0;
    check("both_wready", 64'(wready), 64'd1);
    check("both_rvalid", 64'(rvalid), 64'd1);
    check("both_rdata", rdata, EXP_DATA);
    rready = 1'b1;
    do_w(1, 8'hA1);
    bready = 1'b1;
    wait_b(20);
    wait_r(0, 20);
    bready = 1'b0;
    rready = 1'b0;
    repeat (3) tick();

    check("r_queue_empty", 64'(q_rid.size()), 64'd0);
    check("b_queue_empty", 64'(q_bid.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_decerr_slave.md
AXI_DECERR_SLAVE -- requirements
Module: axi_decerr_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 8: width of all ID fields; set equal to the crossbar M_ID_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: R data width.
REQ-003 SHALL have parameter RESP, default 2'b11 (DECERR): value driven on bresp/rresp.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 s_axi_awid  input  ID_WIDTH  write ID; captured on AW handshake.
REQ-008 s_axi_awvalid / s_axi_awready  input / output  1 / 1  AW handshake pair.
REQ-009 s_axi_wlast / s_axi_wvalid / s_axi_wready  input / input / output  1 / 1 / 1  W beat control; W data is not a port and is discarded.
REQ-010 s_axi_bid / s_axi_bresp  output / output  ID_WIDTH / 2  captured awid / RESP.
REQ-011 s_axi_bvalid / s_axi_bready  output / input  1 / 1  B handshake pair.
REQ-012 s_axi_arid / s_axi_arlen  input / input  ID_WIDTH / 8  read ID and burst length minus one.
REQ-013 s_axi_arvalid / s_axi_arready  input / output  1 / 1  AR handshake pair.
REQ-014 s_axi_rid / s_axi_rdata / s_axi_rresp / s_axi_rlast  output / output / output / output  ID_WIDTH / DATA_WIDTH / 2 / 1  R payload.
REQ-015 s_axi_rvalid / s_axi_rready  output / input  1 / 1  R handshake pair.

Function
REQ-016 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP, independent of the read FSM; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-017 W_IDLE->W_DATA on awvalid&awready, latching awid; W beats presented before AW SHALL stall (wready=0).
REQ-018 W_DATA SHALL accept every beat; on wvalid&wready&wlast the FSM goes to W_RESP, so bvalid rises the next cycle; the awlen/wlast mismatch is not checked.
REQ-019 W_RESP SHALL hold bvalid, bid and bresp=RESP stable until bready; on the handshake the FSM goes to W_IDLE, so awready reasserts the next cycle (one bubble cycle per burst minimum).
REQ-020 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE; on AR handshake it latches arid, loads an 8-bit beat counter with arlen and goes to R_DATA, so rvalid rises the next cycle.
REQ-021 R_DATA SHALL drive rvalid=1, rid=latched ID, rresp=RESP and rlast=(counter==0); each rvalid&rready decrements the counter; the handshake with rlast=1 returns the FSM to R_IDLE.
REQ-022 arlen=0 SHALL yield exactly 1 beat with rlast=1; arlen=255 SHALL yield exactly 256 beats, without counter wrap.
REQ-023 R outputs SHALL stay stable while rvalid=1 and rready=0; B outputs SHALL stay stable while bvalid=1 and bready=0.
REQ-024 Simultaneous AW and AR handshakes SHALL both be accepted in the same cycle.
REQ-025 All outputs SHALL be driven from registers or registered-state decode only, with no combinational input-to-output path.

Reset
REQ-026 While rst_n=0, both FSMs SHALL enter IDLE and the counter and latched IDs SHALL clear; awready, arready, wready, bvalid, rvalid and rlast SHALL be 0, and bid, rid, rdata and rresp SHALL be 0.
REQ-027 awready and arready SHALL be 1 in the first cycle after rst_n=1; reset mid-burst SHALL abandon the burst with no further B or R beats.

Configuration
REQ-028 With macro AXI_DECERR_SLAVE_RDATA_PATTERN_EN defined, rdata SHALL be 32'hDEADBEEF replicated/truncated to DATA_WIDTH in R_DATA; undefined, rdata SHALL be all zeros; the macro SHALL have no other effect.

Verification
REQ-029 AW id=0x5A, then 4 W beats with the last carrying wlast, bready=1 -> bvalid the cycle after wlast, bid=0x5A, bresp=2'b11, awready high one cycle later.
REQ-030 AR id=0x11 arlen=0, rready=1 -> exactly 1 R beat, rlast=1, rid=0x11, rresp=2'b11, arready back next cycle.
REQ-031 AR arlen=255 with rready toggling 50% -> exactly 256 beats, rlast only on beat 256, payload stable during stalls.
REQ-032 W beats offered before AW and bready held 0 for 10 cycles -> wready=0 until the AW handshake; bvalid held with stable bid; no second AW accepted meanwhile.
REQ-033 rst_n=0 for 1 cycle during beat 3 of an arlen=7 burst -> rvalid=0 during reset, arready=1 the next cycle, and a following arlen=1 read returns 2 beats.
REQ-034 Same-cycle AW and AR with the macro defined and DATA_WIDTH=64 -> both accepted; rdata=64'hDEADBEEFDEADBEEF; without the macro rdata=0.
